// File: rtl/pes_crc16_checker.sv
// pes_crc16_checker
//   Receives frames of the form: payload bytes, CRC high byte, CRC low byte.
//   Runs a non-reflected CRC-16 over every accepted byte (CRC bytes included)
//   and declares the frame good when the residue is zero and the frame holds
//   at least three bytes. Payload bytes are passed through a two-byte delay
//   line so that the trailing CRC bytes never reach dout.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        one-cycle pulse opening (or, in RECV, restarting) a frame
//   din_valid    din carries a frame byte this cycle
//   din          received byte, MSB first
//   din_last     with din_valid, marks the final (CRC low) byte
//   dout         payload byte pass-through
//   dout_valid   dout holds a payload byte this cycle
//   busy         high while receiving or checking
//   done         one-cycle end-of-frame pulse
//   crc_ok       frame passed, held until next start
//   crc_err      frame failed, held until next start
//   payload_len  payload byte count, held until next start

module pes_crc16_checker #(
  parameter logic [15:0] POLY = 16'h8005,
  parameter logic [15:0] INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        din_valid,
  input  logic [7:0]  din,
  input  logic        din_last,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic [15:0] payload_len
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [7:0]  sh0_q;      // newest accepted byte
  logic [7:0]  sh1_q;      // byte accepted before sh0_q
  logic        res_ok_q;
  logic [15:0] res_len_q;
  logic        fin_q;

  // One full byte of the serial CRC, MSB first.
  always_comb begin
    crc_d = crc_q;
    for (int unsigned i = 0; i < 8; i++) begin
      if (crc_d[15] ^ din[3'(7 - i)]) begin
        crc_d = {crc_d[14:0], 1'b0} ^ POLY;
      end else begin
        crc_d = {crc_d[14:0], 1'b0};
      end
    end
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 16'd1;
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      cnt_q       <= '0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      res_ok_q    <= 1'b0;
      res_len_q   <= '0;
      fin_q       <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      done        <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      payload_len <= '0;
    end else begin
      dout_valid <= 1'b0;
      done       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RECV;
            crc_q       <= INIT;
            cnt_q       <= '0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            crc_ok      <= 1'b0;
            crc_err     <= 1'b0;
            payload_len <= '0;
            fin_q       <= 1'b0;
          end else if (fin_q) begin
            // Results staged during CHECK are published together with done,
            // two edges after the last byte was sampled.
            fin_q       <= 1'b0;
            done        <= 1'b1;
            crc_ok      <= res_ok_q;
            crc_err     <= ~res_ok_q;
            payload_len <= res_len_q;
          end
        end
        RECV: begin
          if (start) begin
            crc_q <= INIT;
            cnt_q <= '0;
            sh0_q <= '0;
            sh1_q <= '0;
          end else if (din_valid) begin
            crc_q <= crc_d;
            cnt_q <= cnt_d;
            sh0_q <= din;
            sh1_q <= sh0_q;
            // Byte k arriving releases byte k-2; the last two bytes stay
            // in the delay line, which keeps the CRC off dout.
            if (cnt_q >= 16'd2) begin
              dout       <= sh1_q;
              dout_valid <= 1'b1;
            end
            if (din_last) begin
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          res_ok_q  <= (crc_q == '0) && (cnt_q >= 16'd3);
          res_len_q <= (cnt_q >= 16'd3) ? cnt_q - 16'd2 : '0;
          fin_q     <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
